// File: rtl/alu_result_writeback_pkg.sv
// Shared ALU/MEM result-path definitions: widths, the queued writeback entry
// layout and the status-flag bit positions.
package alu_result_writeback_pkg;

   localparam int DATA_W = 16;
   localparam int REG_AW = 3;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;

   typedef struct packed {
      logic              wb;
      logic              flag_en;
      logic [REG_AW-1:0] dest;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   function automatic logic [1:0] calc_flags(input logic [DATA_W-1:0] d);
      logic [1:0] f;
      f         = '0;
      f[FLAG_Z] = (d == '0);
      f[FLAG_N] = d[DATA_W-1];
      return f;
   endfunction

endpackage

// File: rtl/alu_result_writeback_wb_queue.sv
// Small in-order circular FIFO of pending writeback entries. The storage array
// and read pointer are exposed so the owner can scan pending results by age.
module alu_result_writeback_wb_queue
   import alu_result_writeback_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        push_i,
   input  logic                        pop_i,
   input  logic                        clear_i,
   input  wb_entry_t                   entry_i,
   output wb_entry_t                   head_o,
   output logic      [CNT_W-1:0]       count_o,
   output logic      [PTR_W-1:0]       rd_ptr_o,
   output wb_entry_t [DEPTH-1:0]       entries_o
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   wb_entry_t [DEPTH-1:0] mem_q;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointer wrap is plain truncation
         if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_i && !clear_i) mem_q[wr_ptr_q] <= entry_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !clear_i) begin
         assert (!(push_i && count_q == FULL_CNT));
         assert (!(pop_i && count_q == '0));
         assert (count_q <= FULL_CNT);
      end
   end

   assign head_o    = mem_q[rd_ptr_q];
   assign count_o   = count_q;
   assign rd_ptr_o  = rd_ptr_q;
   assign entries_o = mem_q;

endmodule

// File: rtl/alu_result_writeback.sv
// Writeback end of the ALU result path: queues execute results, retires one per
// cycle into the register-file port, tracks Z/N flags and forwards pending data.
module alu_result_writeback
   import alu_result_writeback_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic [DATA_W-1:0] res_data,
   input  logic [REG_AW-1:0] res_dest,
   input  logic              res_wb,
   input  logic              res_flag_en,
   input  logic              flush,
   input  logic              rf_hold,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              zero_flag,
   output logic              neg_flag,
   input  logic [REG_AW-1:0] fwd_qaddr,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_data,
   output logic [CNT_W-1:0]  q_count
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   wb_entry_t             entry_in;
   wb_entry_t             head;
   wb_entry_t [DEPTH-1:0] entries;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  push, pop;

   logic                  rf_we_q;
   logic [REG_AW-1:0]     rf_waddr_q;
   logic [DATA_W-1:0]     rf_wdata_q;
   logic [1:0]            flags_q;

   assign res_ready = (q_count != FULL_CNT);
   assign push      = res_valid && res_ready && !flush;
   assign pop       = (q_count != '0) && !rf_hold && !flush;

   assign entry_in.wb      = res_wb;
   assign entry_in.flag_en = res_flag_en;
   assign entry_in.dest    = res_dest;
   assign entry_in.data    = res_data;

   alu_result_writeback_wb_queue #(.DEPTH(DEPTH)) u_wb_queue (
      .clk       (clk),
      .reset     (reset),
      .push_i    (push),
      .pop_i     (pop),
      .clear_i   (flush),
      .entry_i   (entry_in),
      .head_o    (head),
      .count_o   (q_count),
      .rd_ptr_o  (rd_ptr),
      .entries_o (entries)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         flags_q    <= '0;
      end else if (pop) begin
         rf_we_q    <= head.wb;
         rf_waddr_q <= head.dest;
         rf_wdata_q <= head.data;
         if (head.flag_en) flags_q <= calc_flags(head.data);
      end else begin
         rf_we_q <= 1'b0;
      end
   end

   assign rf_we     = rf_we_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign zero_flag = flags_q[FLAG_Z];
   assign neg_flag  = flags_q[FLAG_N];

   // Scan oldest to youngest so the last match seen is the youngest; the rf
   // output register counts as the oldest pending result.
   logic [PTR_W-1:0] idx;
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = '0;
      if (rf_we_q && rf_waddr_q == fwd_qaddr) begin
         fwd_hit  = 1'b1;
         fwd_data = rf_wdata_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr + PTR_W'(k);
         if (CNT_W'(k) < q_count && entries[idx].wb && entries[idx].dest == fwd_qaddr) begin
            fwd_hit  = 1'b1;
            fwd_data = entries[idx].data;
         end
      end
   end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Directed bench for alu_result_writeback: retire latency, back-pressure,
// flags, forwarding, flush and reset with hand-computed expectations.
module tb_alu_result_writeback;

   logic        clk;
   logic        reset;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic [2:0]  res_dest;
   logic        res_wb;
   logic        res_flag_en;
   logic        flush;
   logic        rf_hold;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic        zero_flag;
   logic        neg_flag;
   logic [2:0]  fwd_qaddr;
   logic        fwd_hit;
   logic [15:0] fwd_data;
   logic [1:0]  q_count;

   int tests = 0;
   int fails = 0;

   alu_result_writeback #(.DEPTH(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_dest    (res_dest),
      .res_wb      (res_wb),
      .res_flag_en (res_flag_en),
      .flush       (flush),
      .rf_hold     (rf_hold),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .zero_flag   (zero_flag),
      .neg_flag    (neg_flag),
      .fwd_qaddr   (fwd_qaddr),
      .fwd_hit     (fwd_hit),
      .fwd_data    (fwd_data),
      .q_count     (q_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] d, input logic [15:0] x,
                        input logic wb, input logic fe);
      res_valid   = v;
      res_dest    = d;
      res_data    = x;
      res_wb      = wb;
      res_flag_en = fe;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; rf_hold = 1'b0; fwd_qaddr = 3'd0;
      drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      step();
      step();
      reset = 1'b0;
      chk("rst_we",    32'(rf_we), 0);
      chk("rst_waddr", 32'(rf_waddr), 0);
      chk("rst_wdata", 32'(rf_wdata), 0);
      chk("rst_zero",  32'(zero_flag), 0);
      chk("rst_neg",   32'(neg_flag), 0);
      chk("rst_count", 32'(q_count), 0);
      chk("rst_ready", 32'(res_ready), 1);
      chk("rst_fwd",   32'(fwd_hit), 0);

      // single result, two-edge latency
      drive(1'b1, 3'd3, 16'h1234, 1'b1, 1'b1);
      step();
      drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      fwd_qaddr = 3'd3;
      #1;
      chk("t1_we_early", 32'(rf_we), 0);
      chk("t1_count",    32'(q_count), 1);
      chk("t1_fwdq_hit", 32'(fwd_hit), 1);
      chk("t1_fwdq_dat", 32'(fwd_data), 32'h1234);
      step();
      chk("t1_we",    32'(rf_we), 1);
      chk("t1_waddr", 32'(rf_waddr), 3);
      chk("t1_wdata", 32'(rf_wdata), 32'h1234);
      chk("t1_zero",  32'(zero_flag), 0);
      chk("t1_neg",   32'(neg_flag), 0);
      chk("t1_cnt0",  32'(q_count), 0);
      chk("t1_fwdrf", 32'(fwd_hit), 1);
      step();
      chk("t1_we_off", 32'(rf_we), 0);
      chk("t1_fwdoff", 32'(fwd_hit), 0);

      // back-pressure: hold four cycles, third result must be refused
      rf_hold = 1'b1;
      drive(1'b1, 3'd1, 16'h0011, 1'b1, 1'b0);
      step();
      chk("t2_ready1", 32'(res_ready), 1);
      chk("t2_cnt1",   32'(q_count), 1);
      drive(1'b1, 3'd2, 16'h0022, 1'b1, 1'b0);
      step();
      chk("t2_ready0", 32'(res_ready), 0);
      chk("t2_cnt2",   32'(q_count), 2);
      drive(1'b1, 3'd4, 16'h0044, 1'b1, 1'b0);
      step();
      step();
      chk("t2_full_cnt", 32'(q_count), 2);
      chk("t2_held_we",  32'(rf_we), 0);
      drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      rf_hold = 1'b0;
      step();
      chk("t2_r1_we",    32'(rf_we), 1);
      chk("t2_r1_waddr", 32'(rf_waddr), 1);
      chk("t2_r1_wdata", 32'(rf_wdata), 32'h0011);
      chk("t2_r1_cnt",   32'(q_count), 1);
      step();
      chk("t2_r2_we",    32'(rf_we), 1);
      chk("t2_r2_waddr", 32'(rf_waddr), 2);
      chk("t2_r2_wdata", 32'(rf_wdata), 32'h0022);
      chk("t2_r2_cnt",   32'(q_count), 0);
      step();
      chk("t2_no_third", 32'(rf_we), 0);

      // flags-only entry, then a negative flagged result
      drive(1'b1, 3'd6, 16'h0000, 1'b0, 1'b1);
      step();
      drive(1'b1, 3'd7, 16'h8000, 1'b1, 1'b1);
      step();
      drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      chk("t3_fo_we",   32'(rf_we), 0);
      chk("t3_fo_zero", 32'(zero_flag), 1);
      chk("t3_fo_neg",  32'(neg_flag), 0);
      chk("t3_fo_cnt",  32'(q_count), 1);
      step();
      chk("t3_n_we",    32'(rf_we), 1);
      chk("t3_n_waddr", 32'(rf_waddr), 7);
      chk("t3_n_wdata", 32'(rf_wdata), 32'h8000);
      chk("t3_n_zero",  32'(zero_flag), 0);
      chk("t3_n_neg",   32'(neg_flag), 1);
      step();

      // forwarding: youngest of two matching entries wins
      rf_hold = 1'b1;
      drive(1'b1, 3'd5, 16'hAAAA, 1'b1, 1'b0);
      step();
      fwd_qaddr = 3'd5;
      #1;
      chk("t4_fwd_one", 32'(fwd_data), 32'hAAAA);
      drive(1'b1, 3'd5, 16'hBBBB, 1'b1, 1'b0);
      step();
      drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      #1;
      chk("t4_hit5",  32'(fwd_hit), 1);
      chk("t4_data5", 32'(fwd_data), 32'hBBBB);
      fwd_qaddr = 3'd2;
      #1;
      chk("t4_hit2",  32'(fwd_hit), 0);
      chk("t4_data2", 32'(fwd_data), 0);

      // flush while full with push and pop requested
      rf_hold = 1'b0;
      flush   = 1'b1;
      drive(1'b1, 3'd1, 16'hCCCC, 1'b1, 1'b1);
      step();
      flush = 1'b0;
      drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      fwd_qaddr = 3'd5;
      #1;
      chk("t5_cnt",   32'(q_count), 0);
      chk("t5_we",    32'(rf_we), 0);
      chk("t5_ready", 32'(res_ready), 1);
      chk("t5_fwd",   32'(fwd_hit), 0);
      chk("t5_wdata_hold", 32'(rf_wdata), 32'h8000);
      chk("t5_neg_hold",   32'(neg_flag), 1);
      step();
      chk("t5_we_after", 32'(rf_we), 0);
      step();
      chk("t5_we_after2", 32'(rf_we), 0);

      // reset with results pending and rf_we high
      rf_hold = 1'b1;
      drive(1'b1, 3'd2, 16'h1111, 1'b1, 1'b0);
      step();
      drive(1'b1, 3'd3, 16'h2222, 1'b1, 1'b0);
      step();
      drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      rf_hold = 1'b0;
      step();
      chk("t6_pre_we",  32'(rf_we), 1);
      chk("t6_pre_cnt", 32'(q_count), 1);
      chk("t6_pre_neg", 32'(neg_flag), 1);
      reset = 1'b1;
      drive(1'b1, 3'd4, 16'h3333, 1'b1, 1'b1);
      step();
      reset = 1'b0;
      drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      fwd_qaddr = 3'd3;
      #1;
      chk("t6_we",    32'(rf_we), 0);
      chk("t6_waddr", 32'(rf_waddr), 0);
      chk("t6_wdata", 32'(rf_wdata), 0);
      chk("t6_zero",  32'(zero_flag), 0);
      chk("t6_neg",   32'(neg_flag), 0);
      chk("t6_cnt",   32'(q_count), 0);
      chk("t6_ready", 32'(res_ready), 1);
      chk("t6_fwd",   32'(fwd_hit), 0);
      step();
      chk("t6_we_later", 32'(rf_we), 0);
      step();
      chk("t6_we_later2", 32'(rf_we), 0);
      chk("t6_wdata_later", 32'(rf_wdata), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
